delta_sigma_decimator: RTL

Receive-side reconstruction for the noise-shaping DAC. Takes the modulator's OUT_BITS sample stream (y, y_valid) and low-pass filters it with an ORDER-stage CIC filter, decimating by R = 2^R_LOG2. The result is an IN_BITS estimate u_hat of the modulator input u. Used as an on-chip loopback monitor and as a bench checker.

---
 rtl/delta_sigma_pkg.sv | 30 +++
 rtl/delta_sigma_decimator_cic_integrator_chain.sv | 46 ++++
 rtl/delta_sigma_decimator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/delta_sigma_pkg.sv
// rtl/delta_sigma_pkg.sv - shared constants, sizing helpers and FSM state type for the decimators
// Holds the default filter configuration and its derived sizes. Sizing helpers
// let parameterised variants derive the same quantities from their own parameters.
package delta_sigma_pkg;

  localparam int DEF_IN_BITS   = 16;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_OUT_BITS  = 9;
  localparam int DEF_ORDER     = 3;
  localparam int DEF_R_LOG2    = 4;

  localparam int ACC_BITS    = DEF_OUT_BITS + DEF_ORDER * DEF_R_LOG2;
  localparam int DECIM_SHIFT = DEF_ORDER * DEF_R_LOG2 - DEF_FRAC_BITS;
  localparam int SKIP_COUNT  = DEF_ORDER + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COMB = 2'd1,
    ST_OUT  = 2'd2
  } dsd_state_e;

  function automatic int calc_acc_bits(input int out_bits, input int order, input int r_log2);
    return out_bits + order * r_log2;
  endfunction

  function automatic int calc_decim_shift(input int order, input int r_log2, input int frac_bits);
    return order * r_log2 - frac_bits;
  endfunction

endpackage

// File: rtl/delta_sigma_decimator_cic_integrator_chain.sv
// rtl/delta_sigma_decimator_cic_integrator_chain.sv - cascade of ORDER registered CIC integrators
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear of all integrators (priority over en_i)
//   en_i            accept din_i this cycle
//   din_i           unsigned input sample, zero-extended into the accumulators
//   last_next_o     value the last integrator will take if this sample is accepted
module cic_integrator_chain
  import delta_sigma_pkg::*;
#(
  parameter int IN_W  = DEF_OUT_BITS,
  parameter int ACC_W = ACC_BITS,
  parameter int ORDER = DEF_ORDER
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  din_i,
  output logic [ACC_W-1:0] last_next_o
);

  logic [ACC_W-1:0] int_q [ORDER];
  logic [ACC_W-1:0] int_d [ORDER];

  // Every stage adds the pre-update value of its predecessor; sums wrap mod 2^ACC_W.
  always_comb begin
    int_d[0] = int_q[0] + ACC_W'(din_i);
    for (int k = 1; k < ORDER; k++) begin
      int_d[k] = int_q[k] + int_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < ORDER; k++) int_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < ORDER; k++) int_q[k] <= '0;
    end else if (en_i) begin
      for (int k = 0; k < ORDER; k++) int_q[k] <= int_d[k];
    end
  end

  assign last_next_o = int_d[ORDER-1];

endmodule

// File: rtl/delta_sigma_decimator.sv
// rtl/delta_sigma_decimator.sv - CIC reconstruction filter decimating the modulator stream to u_hat
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous clear of all filter state (priority over y_valid)
//   y, y_valid      unsigned modulator samples, any duty cycle
//   u_hat           saturated reconstructed sample
//   u_hat_valid     one-cycle pulse when u_hat updates
//   settled         high once the start-up outputs have been skipped
module delta_sigma_decimator
  import delta_sigma_pkg::*;
#(
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  parameter int ORDER     = DEF_ORDER,
  parameter int R_LOG2    = DEF_R_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [OUT_BITS-1:0] y,
  input  logic                y_valid,
  output logic [IN_BITS-1:0]  u_hat,
  output logic                u_hat_valid,
  output logic                settled
);

  localparam int ACC_W  = calc_acc_bits(OUT_BITS, ORDER, R_LOG2);
  localparam int SHIFT  = calc_decim_shift(ORDER, R_LOG2, FRAC_BITS);
  localparam int SKIP_N = ORDER + 1;
  localparam int STG_W  = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int SKP_W  = $clog2(SKIP_N + 1);
  localparam logic [ACC_W-1:0] U_MAX = ACC_W'((64'd1 << IN_BITS) - 64'd1);

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("ORDER must be in 1..4");
  end
  if (ORDER * R_LOG2 < FRAC_BITS) begin : g_bad_gain
    $error("ORDER*R_LOG2 must be >= FRAC_BITS");
  end
  // A decimation event must never arrive while the comb pass is still busy.
  if ((1 << R_LOG2) < ORDER + 2) begin : g_bad_ratio
    $error("decimation ratio must be >= ORDER+2");
  end
  if (ACC_W < IN_BITS) begin : g_bad_width
    $error("accumulator narrower than output");
  end

  dsd_state_e       state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [R_LOG2-1:0] dcnt_q;
  logic [ACC_W-1:0] x_q;          // snapshot, then running comb result
  logic [ACC_W-1:0] dly_q [ORDER];
  logic [SKP_W-1:0] skip_q;
  logic [IN_BITS-1:0] u_hat_q;
  logic             u_hat_valid_q;
  logic             settled_q;

  logic             accept;
  logic             decim;
  logic             snap_en, comb_en, out_en;
  logic [ACC_W-1:0] last_next;
  logic [ACC_W-1:0] dly_sel;
  logic [ACC_W-1:0] diff;
  logic [ACC_W-1:0] shifted;
  logic [IN_BITS-1:0] sat;

  assign accept = y_valid & ~clear;
  assign decim  = accept && (dcnt_q == '1);

  cic_integrator_chain #(
    .IN_W  (OUT_BITS),
    .ACC_W (ACC_W),
    .ORDER (ORDER)
  ) u_chain (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .en_i        (y_valid),
    .din_i       (y),
    .last_next_o (last_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: if (decim) begin
        state_d = ST_COMB;
        stage_d = '0;
      end
      ST_COMB: begin
        if (stage_q == STG_W'(ORDER - 1)) state_d = ST_OUT;
        else stage_d = stage_q + 1'b1;
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    snap_en = (state_q == ST_IDLE) && decim;
    comb_en = (state_q == ST_COMB);
    out_en  = (state_q == ST_OUT);
  end

  // Single subtractor shared by all comb stages; stage_q selects the delay register.
  always_comb begin
    dly_sel = '0;
    for (int k = 0; k < ORDER; k++) begin
      if (stage_q == STG_W'(k)) dly_sel = dly_q[k];
    end
  end
  assign diff = x_q - dly_sel;

  assign shifted = x_q >> SHIFT;
  assign sat     = (shifted > U_MAX) ? '1 : shifted[IN_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q        <= '0;
      x_q           <= '0;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      skip_q        <= '0;
      u_hat_q       <= '0;
      u_hat_valid_q <= 1'b0;
      settled_q     <= 1'b0;
    end else if (clear) begin
      dcnt_q        <= '0;
      x_q           <= '0;
      for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      skip_q        <= '0;
      u_hat_q       <= '0;
      u_hat_valid_q <= 1'b0;
      settled_q     <= 1'b0;
    end else begin
      u_hat_valid_q <= 1'b0;
      if (accept) dcnt_q <= dcnt_q + 1'b1;
      if (snap_en) begin
        x_q <= last_next;
      end else if (comb_en) begin
        x_q <= diff;
        for (int k = 0; k < ORDER; k++) begin
          if (stage_q == STG_W'(k)) dly_q[k] <= x_q;
        end
      end
      if (out_en) begin
        // Early outputs carry the filter's start-up transient and are dropped.
        if (skip_q == SKP_W'(SKIP_N)) begin
          u_hat_q       <= sat;
          u_hat_valid_q <= 1'b1;
          settled_q     <= 1'b1;
        end else begin
          skip_q <= skip_q + 1'b1;
        end
      end
    end
  end

  assign u_hat       = u_hat_q;
  assign u_hat_valid = u_hat_valid_q;
  assign settled     = settled_q;

endmodule
